// File: rtl/wb_systolic_mm.sv
// Wishbone-slave matrix multiplier: C = X*W on a weight-stationary NxN systolic MAC array.
// Four-word register window: CTRL/STATUS, WEIGHT, INPUT, RESULT.
module wb_systolic_mm #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          N            = 3,
    parameter int          DW           = 8,
    parameter int          AW           = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        irq_o
);

    localparam int NN = N * N;
    localparam int PW = $clog2(NN + 1);
    localparam int CW = $clog2(3 * N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   w_ptr_q, w_ptr_d, x_ptr_q, x_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sat_q, sat_d, irq_en_q, irq_en_d, err_q, err_d, ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;

    logic signed [DW-1:0] w_buf_q [NN];
    logic signed [DW-1:0] w_buf_d [NN];
    logic signed [DW-1:0] x_buf_q [NN];
    logic signed [DW-1:0] x_buf_d [NN];
    logic signed [AW-1:0] c_buf_q [NN];
    logic signed [AW-1:0] c_buf_d [NN];
    logic signed [DW-1:0] xp_q [N][N];
    logic signed [DW-1:0] xp_d [N][N];
    logic signed [AW-1:0] ps_q [N][N];
    logic signed [AW-1:0] ps_d [N][N];

    logic [31:0] offset;
    logic        in_range, req, busy, done, w_full, x_full;
    logic [31:0] status, result;
    logic        unused_bits;

    // Signed multiply-accumulate; in SAT mode each partial sum is clamped to the AW-bit range.
    function automatic logic signed [AW-1:0] mac(input logic signed [AW-1:0] acc,
                                                 input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b,
                                                 input logic                 sat);
        logic [2*DW-1:0] prod;
        logic [AW:0]     sum;
        prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
        sum  = {acc[AW-1], acc} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
        if (sat && (sum[AW] != sum[AW-1]))
            mac = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            mac = sum[AW-1:0];
    endfunction

    assign offset   = wb_adr_i - BASE_ADDRESS;
    assign in_range = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
    assign req      = wb_stb_i & wb_cyc_i & in_range & ~ack_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign w_full   = (int'(w_ptr_q) == NN);
    assign x_full   = (int'(x_ptr_q) == NN);
    assign status   = {25'd0, irq_en_q, sat_q, err_q, x_full, w_full, done, busy};
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = done & irq_en_q;

    always_comb begin
        result = 32'd0;
        if (done) begin
            for (int e = 0; e < NN; e++) begin
                if (int'(r_ptr_q) == e) result = 32'(c_buf_q[e]);
            end
        end
    end

    always_comb begin
        unused_bits = ^{wb_sel_i, wb_dat_i[31:DW]};
        for (int k = 0; k < N; k++) unused_bits = unused_bits ^ (^xp_q[k][N-1]);
    end

    // Row k of X is skewed by k cycles; partial sums flow down, operands flow right.
    always_comb begin
        int                   cnt;
        logic signed [DW-1:0] feed [N];
        logic signed [DW-1:0] x_in;
        logic signed [AW-1:0] p_in;
        cnt     = int'(count_q);
        c_buf_d = c_buf_q;
        x_in    = '0;
        p_in    = '0;
        for (int k = 0; k < N; k++) begin
            feed[k] = '0;
            for (int i = 0; i < N; i++) begin
                if (cnt == i + k) feed[k] = x_buf_q[i*N+k];
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                x_in = (j == 0) ? feed[k] : xp_q[k][(j > 0) ? j - 1 : 0];
                p_in = (k == 0) ? '0 : ps_q[(k > 0) ? k - 1 : 0][j];
                xp_d[k][j] = busy ? x_in : '0;
                ps_d[k][j] = busy ? mac(p_in, x_in, w_buf_q[k*N+j], sat_q) : '0;
            end
        end
        if (busy) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (cnt == i + j + N) c_buf_d[i*N+j] = ps_q[N-1][j];
                end
            end
        end
    end

    // Bus decode and FSM: the access is applied at the edge that raises ack.
    always_comb begin
        state_d  = state_q;
        w_ptr_d  = w_ptr_q;
        x_ptr_d  = x_ptr_q;
        r_ptr_d  = r_ptr_q;
        count_d  = count_q;
        sat_d    = sat_q;
        irq_en_d = irq_en_q;
        err_d    = err_q;
        dat_d    = dat_q;
        ack_d    = req;
        w_buf_d  = w_buf_q;
        x_buf_d  = x_buf_q;
        if (busy) begin
            count_d = count_q + CW'(1);
            if (int'(count_q) == 3 * N - 1) state_d = DONE;
        end
        if (req) begin
            if (wb_we_i) begin
                dat_d = 32'd0;
                case (offset[3:2])
                    2'd0: begin
                        if (wb_dat_i[1]) begin
                            state_d  = IDLE;
                            w_ptr_d  = '0;
                            x_ptr_d  = '0;
                            r_ptr_d  = '0;
                            count_d  = '0;
                            err_d    = 1'b0;
                            sat_d    = wb_dat_i[2];
                            irq_en_d = wb_dat_i[3];
                        end else if (busy) begin
                            err_d = 1'b1;
                        end else begin
                            sat_d    = wb_dat_i[2];
                            irq_en_d = wb_dat_i[3];
                            if (wb_dat_i[0]) begin
                                if (w_full && x_full) begin
                                    state_d = RUN;
                                    count_d = '0;
                                    r_ptr_d = '0;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                    end
                    2'd1: begin
                        if (w_full || busy) begin
                            err_d = 1'b1;
                        end else begin
                            for (int e = 0; e < NN; e++) begin
                                if (int'(w_ptr_q) == e) w_buf_d[e] = wb_dat_i[DW-1:0];
                            end
                            w_ptr_d = w_ptr_q + PW'(1);
                        end
                    end
                    2'd2: begin
                        if (x_full || busy) begin
                            err_d = 1'b1;
                        end else begin
                            for (int e = 0; e < NN; e++) begin
                                if (int'(x_ptr_q) == e) x_buf_d[e] = wb_dat_i[DW-1:0];
                            end
                            x_ptr_d = x_ptr_q + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (offset[3:2])
                    2'd0: dat_d = status;
                    2'd3: begin
                        dat_d = result;
                        if (done) r_ptr_d = (int'(r_ptr_q) == NN - 1) ? '0 : r_ptr_q + PW'(1);
                    end
                    default: dat_d = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            w_ptr_q  <= '0;
            x_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            irq_en_q <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            xp_q     <= '{default: '0};
            ps_q     <= '{default: '0};
        end else begin
            state_q  <= state_d;
            w_ptr_q  <= w_ptr_d;
            x_ptr_q  <= x_ptr_d;
            r_ptr_q  <= r_ptr_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            irq_en_q <= irq_en_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            xp_q     <= xp_d;
            ps_q     <= ps_d;
        end
    end

    // Operand and result buffers are never cleared; result reads are gated by DONE.
    always_ff @(posedge clock) begin
        w_buf_q <= w_buf_d;
        x_buf_q <= x_buf_d;
        c_buf_q <= c_buf_d;
    end

endmodule

// File: tb/tb_wb_systolic_mm.sv
// Bench for wb_systolic_mm: directed bus traffic checked against a behavioural matrix model
// plus literal expectations for the key results.
module tb_wb_systolic_mm;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int N  = 3;
    localparam int NN = 9;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_i = 32'd0, adr = 32'd0;
    logic        ack, irq;
    logic [31:0] dat_o;

    wb_systolic_mm #(.BASE_ADDRESS(BASE), .N(N), .DW(8), .AW(16)) dut (
        .clock(clock), .rst(rst), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_adr_i(adr),
        .wb_ack_o(ack), .wb_dat_o(dat_o), .irq_o(irq)
    );

    always #5 clock = ~clock;

    int cycle_no = 0;
    always @(posedge clock) cycle_no <= cycle_no + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model state
    int m_w[NN], m_x[NN], m_c[NN];
    int m_wptr, m_xptr, m_rptr, m_done_at;
    bit m_run, m_sat, m_irq_en, m_err;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic int fit(input int v, input bit sat);
        int r;
        r = v;
        if (sat) begin
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
        end else begin
            r = r & 32'hFFFF;
            if (r >= 32768) r = r - 65536;
        end
        return r;
    endfunction

    function automatic bit m_busy(input int q);
        return m_run && (q < m_done_at);
    endfunction

    function automatic bit m_done(input int q);
        return m_run && (q >= m_done_at);
    endfunction

    function automatic logic [31:0] m_status(input int q);
        return {25'd0, m_irq_en, m_sat, m_err, (m_xptr == NN), (m_wptr == NN), m_done(q), m_busy(q)};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] off, input int q);
        if (off == 32'h0) return m_status(q);
        if (off == 32'hC) return m_done(q) ? m_c[m_rptr] : 0;
        return 32'd0;
    endfunction

    task automatic compute_c();
        int acc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc = fit(acc + m_x[i*N+k] * m_w[k*N+j], m_sat);
                m_c[i*N+j] = acc;
            end
        end
    endtask

    task automatic m_apply(input bit w, input logic [31:0] off, input logic [31:0] d, input int q);
        if (w) begin
            if (off == 32'h0) begin
                if (d[1]) begin
                    m_run = 0; m_wptr = 0; m_xptr = 0; m_rptr = 0; m_err = 0;
                    m_sat = d[2]; m_irq_en = d[3];
                end else if (m_busy(q)) begin
                    m_err = 1;
                end else begin
                    m_sat = d[2]; m_irq_en = d[3];
                    if (d[0]) begin
                        if (m_wptr == NN && m_xptr == NN) begin
                            m_run = 1; m_done_at = q + 1 + 3 * N; m_rptr = 0;
                            compute_c();
                        end else begin
                            m_err = 1;
                        end
                    end
                end
            end else if (off == 32'h4) begin
                if (m_wptr == NN || m_busy(q)) m_err = 1;
                else begin m_w[m_wptr] = int'($signed(d[7:0])); m_wptr++; end
            end else if (off == 32'h8) begin
                if (m_xptr == NN || m_busy(q)) m_err = 1;
                else begin m_x[m_xptr] = int'($signed(d[7:0])); m_xptr++; end
            end
        end else if (off == 32'hC && m_done(q)) begin
            m_rptr = (m_rptr + 1) % NN;
        end
    endtask

    task automatic apply_stimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rdata);
        logic [31:0] off;
        bit          inr;
        int          q;
        exp_t        e;
        @(posedge clock); #1;
        q   = cycle_no;
        off = a - BASE;
        inr = (off < 32'd16) && (off[1:0] == 2'b00);
        if (inr) begin
            e.is_read = !w;
            e.data    = w ? 32'd0 : m_read(off, q);
            exp_q.push_back(e);
        end
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        @(posedge clock); #1;
        rdata = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (inr) begin
            check_output("ack_latency", {31'd0, ack}, 32'd1);
            if (ack) m_apply(w, off, d, q);
            else exp_q.pop_back();
        end else begin
            check_output("oor_no_ack", {31'd0, ack}, 32'd0);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r;
        apply_stimulus(1'b1, BASE + off, d, r);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] r);
        apply_stimulus(1'b0, BASE + off, 32'd0, r);
    endtask

    task automatic wait_done();
        logic [31:0] r;
        bit          seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rd(32'h0, r);
            seen = r[1];
        end
        check_output("done_within_bound", {31'd0, seen}, 32'd1);
    endtask

    // Per-cycle comparison of irq, ack spacing and read data against the model.
    logic prev_ack = 1'b0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (rst) begin
            prev_ack <= 1'b0;
        end else begin
            check_output("irq_model", {31'd0, irq}, {31'd0, (m_irq_en && m_done(cycle_no))});
            if (ack) begin
                check_output("ack_not_consecutive", {31'd0, prev_ack}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack actual=1 expected=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_read) check_output("read_data_model", dat_o, mon_e.data);
                end
            end
            prev_ack <= ack;
        end
    end

    initial begin
        logic [31:0] r;
        int          q;
        int          xv[NN];
        exp_t        e;
        xv = '{-1, 2, 0, 3, -4, 5, 1, 1, 1};
        m_wptr = 0; m_xptr = 0; m_rptr = 0; m_done_at = 0;
        m_run = 0; m_sat = 0; m_irq_en = 0; m_err = 0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;

        $display("[TB] reset state");
        check_output("reset_ack", {31'd0, ack}, 32'd0);
        check_output("reset_dat", dat_o, 32'd0);
        check_output("reset_irq", {31'd0, irq}, 32'd0);
        rd(32'h0, r); check_output("reset_status", r, 32'd0);
        rd(32'hC, r); check_output("reset_result", r, 32'd0);

        $display("[TB] identity weights");
        for (int e2 = 0; e2 < NN; e2++) wr(32'h4, (e2 % 4 == 0) ? 32'd1 : 32'd0);
        for (int e2 = 0; e2 < NN; e2++) wr(32'h8, 32'(e2 + 1));
        wr(32'h0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock); #1;
            if (k == 8) check_output("irq_before_done", {31'd0, irq}, 32'd0);
            if (k == 9) check_output("irq_at_done", {31'd0, irq}, 32'd1);
        end
        for (int e2 = 0; e2 < NN; e2++) begin
            rd(32'hC, r); check_output("result_identity", r, 32'(e2 + 1));
        end
        rd(32'hC, r); check_output("result_wrap", r, 32'd1);

        $display("[TB] overflow of weight buffer");
        wr(32'h4, 32'd5);
        rd(32'h0, r); check_output("status_w_overflow", r, 32'h5E);
        rd(32'hC, r); check_output("result_unchanged", r, 32'd2);

        $display("[TB] -128 operands, wrap and saturate");
        wr(32'h0, 32'h2);
        for (int e2 = 0; e2 < NN; e2++) wr(32'h4, 32'h80);
        for (int e2 = 0; e2 < NN - 1; e2++) wr(32'h8, 32'h80);
        wr(32'h0, 32'h1);
        rd(32'h0, r); check_output("status_start_not_full", r, 32'h14);
        wr(32'h8, 32'h80);
        wr(32'h0, 32'h1);
        wait_done();
        for (int e2 = 0; e2 < NN; e2++) begin
            rd(32'hC, r); check_output("result_wrap_mode", r, 32'hFFFF_C000);
        end
        wr(32'h0, 32'h5);
        wait_done();
        for (int e2 = 0; e2 < NN; e2++) begin
            rd(32'hC, r); check_output("result_sat_mode", r, 32'h0000_7FFF);
        end

        $display("[TB] clear during run, reload");
        wr(32'h0, 32'h1);
        repeat (3) @(posedge clock);
        wr(32'h0, 32'h2);
        rd(32'h0, r); check_output("status_after_clear", r, 32'd0);
        rd(32'hC, r); check_output("result_after_clear", r, 32'd0);
        for (int e2 = 0; e2 < NN; e2++) wr(32'h4, 32'(e2 + 1));
        for (int e2 = 0; e2 < NN; e2++) wr(32'h8, 32'(xv[e2]));
        wr(32'h0, 32'h1);
        wr(32'h0, 32'h8);
        rd(32'h0, r); check_output("status_busy_err", r, 32'h1D);
        wait_done();
        rd(32'hC, r); check_output("result_reload_c00", r, 32'd7);
        for (int e2 = 1; e2 < NN; e2++) rd(32'hC, r);

        $display("[TB] back-to-back strobe and out-of-range address");
        @(posedge clock); #1;
        q = cycle_no;
        e.is_read = 1'b1;
        e.data = m_status(q);
        exp_q.push_back(e);
        e.data = m_status(q + 2);
        exp_q.push_back(e);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
        check_output("b2b_ack_0", {31'd0, ack}, 32'd0);
        @(posedge clock); #1; check_output("b2b_ack_1", {31'd0, ack}, 32'd1);
        @(posedge clock); #1; check_output("b2b_ack_2", {31'd0, ack}, 32'd0);
        @(posedge clock); #1; check_output("b2b_ack_3", {31'd0, ack}, 32'd1);
        stb = 1'b0; cyc = 1'b0;
        apply_stimulus(1'b1, BASE + 32'h10, 32'h2, r);
        apply_stimulus(1'b0, BASE + 32'h10, 32'h0, r);
        rd(32'h0, r); check_output("status_after_oor", r, 32'h1E);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
